// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. The master is the pipeline/cache side;
// the slave is the hazard unit itself.
interface hazard_unit_if #(
    parameter int unsigned PERF_W = 32
);
    logic [4:0]        rs1_id;
    logic [4:0]        rs2_id;
    logic              use_rs1_id;
    logic              use_rs2_id;
    logic [4:0]        rd_ex;
    logic              ex_is_load;
    logic              br_taken_ex;
    logic [31:0]       br_target_ex;
    logic              imem_req;
    logic              imem_resp;
    logic              dmem_req;
    logic              dmem_resp;
    logic              freeze;
    logic              stall_front;
    logic              flush_ifid;
    logic              flush_idex;
    logic              pc_redirect;
    logic [31:0]       pc_redirect_target;
    logic [PERF_W-1:0] perf_stall_cycles;

    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, ex_is_load,
               br_taken_ex, br_target_ex, imem_req, imem_resp, dmem_req, dmem_resp,
        input  freeze, stall_front, flush_ifid, flush_idex, pc_redirect,
               pc_redirect_target, perf_stall_cycles
    );

    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, ex_is_load,
               br_taken_ex, br_target_ex, imem_req, imem_resp, dmem_req, dmem_resp,
        output freeze, stall_front, flush_ifid, flush_idex, pc_redirect,
               pc_redirect_target, perf_stall_cycles
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use bubbles, branch redirects (deferred behind an
// imem miss), data-cache freeze. Define HAZARD_PERF_EN to enable the stall counter.
module hazard_unit #(
    parameter int unsigned PERF_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave bus
);
    typedef enum logic {RUN, REDIR_WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic        load_use, imem_miss;
    logic        freeze_c, stall_c, flush_ifid_c, flush_idex_c, redir_c;
    logic [31:0] redir_tgt_c;

    assign load_use = bus.ex_is_load && (bus.rd_ex != 5'd0) &&
                      ((bus.use_rs1_id && (bus.rs1_id == bus.rd_ex)) ||
                       (bus.use_rs2_id && (bus.rs2_id == bus.rd_ex)));
    assign imem_miss = bus.imem_req && !bus.imem_resp;

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        freeze_c     = bus.dmem_req && !bus.dmem_resp;
        stall_c      = 1'b0;
        flush_ifid_c = 1'b0;
        flush_idex_c = 1'b0;
        redir_c      = 1'b0;
        redir_tgt_c  = '0;
        if (!rst_n) begin
            // Reset presents empty pipeline registers with nothing held or frozen.
            freeze_c     = 1'b0;
            flush_ifid_c = 1'b1;
            flush_idex_c = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (freeze_c) begin
                        stall_c = 1'b1;
                    end else if (bus.br_taken_ex) begin
                        flush_ifid_c = 1'b1;
                        flush_idex_c = 1'b1;
                        if (imem_miss) begin
                            // Outstanding fetch must drain before the PC may move.
                            stall_c = 1'b1;
                            tgt_d   = bus.br_target_ex;
                            state_d = REDIR_WAIT;
                        end else begin
                            redir_c     = 1'b1;
                            redir_tgt_c = bus.br_target_ex;
                        end
                    end else if (load_use || imem_miss) begin
                        stall_c      = 1'b1;
                        flush_idex_c = 1'b1;
                    end
                end
                REDIR_WAIT: begin
                    stall_c      = 1'b1;
                    flush_ifid_c = !freeze_c;
                    flush_idex_c = !freeze_c;
                    if (bus.imem_resp) begin
                        redir_c     = 1'b1;
                        redir_tgt_c = tgt_q;
                        state_d     = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    assign bus.freeze             = freeze_c;
    assign bus.stall_front        = stall_c;
    assign bus.flush_ifid         = flush_ifid_c;
    assign bus.flush_idex         = flush_idex_c;
    assign bus.pc_redirect        = redir_c;
    assign bus.pc_redirect_target = redir_tgt_c;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (freeze_c || stall_c) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    assign bus.perf_stall_cycles = perf_q;
`else
    assign bus.perf_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_hazard_unit;
    localparam int unsigned PW = 8;
`ifdef HAZARD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_unit_if #(.PERF_W(PW)) bus ();
    hazard_unit #(.PERF_W(PW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending redirect is a target waiting in a queue.
    logic [31:0] pend_q[$];
    int unsigned m_cnt = 0;

    initial begin : model
        logic e_frz, e_st, e_fi, e_fx, e_pr, push, pop, lu, imiss;
        logic [31:0] e_tg, push_val;
        forever begin
            @(negedge clk);
            e_frz = bus.dmem_req && !bus.dmem_resp;
            lu = bus.ex_is_load && bus.rd_ex != 0 &&
                 ((bus.use_rs1_id && bus.rs1_id == bus.rd_ex) ||
                  (bus.use_rs2_id && bus.rs2_id == bus.rd_ex));
            imiss = bus.imem_req && !bus.imem_resp;
            e_st = 0; e_fi = 0; e_fx = 0; e_pr = 0; e_tg = 0;
            push = 0; pop = 0; push_val = 0;
            if (!rst_n) begin
                e_frz = 0; e_fi = 1; e_fx = 1;
            end else if (pend_q.size() != 0) begin
                e_st = 1; e_fi = !e_frz; e_fx = !e_frz;
                if (bus.imem_resp) begin e_pr = 1; e_tg = pend_q[0]; pop = 1; end
            end else if (e_frz) begin
                e_st = 1;
            end else if (bus.br_taken_ex) begin
                e_fi = 1; e_fx = 1;
                if (imiss) begin e_st = 1; push = 1; push_val = bus.br_target_ex; end
                else begin e_pr = 1; e_tg = bus.br_target_ex; end
            end else if (lu || imiss) begin
                e_st = 1; e_fx = 1;
            end
            chk("m_freeze", bus.freeze, e_frz);
            chk("m_stall_front", bus.stall_front, e_st);
            chk("m_flush_ifid", bus.flush_ifid, e_fi);
            chk("m_flush_idex", bus.flush_idex, e_fx);
            chk("m_pc_redirect", bus.pc_redirect, e_pr);
            chk("m_redirect_target", bus.pc_redirect_target, e_tg);
            chk("m_perf", bus.perf_stall_cycles, PERF_ON ? m_cnt : 0);
            @(posedge clk);
            if (!rst_n) begin
                pend_q.delete();
                m_cnt = 0;
            end else begin
                if (e_frz || e_st) m_cnt = (m_cnt + 1) % (1 << PW);
                if (pop) pend_q.delete(0);
                if (push) pend_q.push_back(push_val);
            end
        end
    end

    task automatic clear();
        bus.rs1_id = 0; bus.rs2_id = 0; bus.use_rs1_id = 0; bus.use_rs2_id = 0;
        bus.rd_ex = 0; bus.ex_is_load = 0; bus.br_taken_ex = 0; bus.br_target_ex = 0;
        bus.imem_req = 0; bus.imem_resp = 0; bus.dmem_req = 0; bus.dmem_resp = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic branch(input logic [31:0] tgt, input logic miss);
        clear();
        bus.br_taken_ex = 1; bus.br_target_ex = tgt;
        bus.imem_req = miss;
    endtask

    task automatic reset_pulse();
        clear(); rst_n = 0;
        sample();
        chk("rst_stall", bus.stall_front, 0);
        chk("rst_flush_idex", bus.flush_idex, 1);
        tick();
        rst_n = 1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 0; clear();
        bus.dmem_req = 1;
        sample();
        chk("rst_freeze", bus.freeze, 0);
        chk("rst_flush_ifid", bus.flush_ifid, 1);
        chk("rst_flush_idex", bus.flush_idex, 1);
        chk("rst_pc_redirect", bus.pc_redirect, 0);
        chk("rst_perf", bus.perf_stall_cycles, 0);
        tick();
        clear(); rst_n = 1;

        // load-use on rs1, then the bubbled cycle
        bus.ex_is_load = 1; bus.rd_ex = 5; bus.rs1_id = 5; bus.use_rs1_id = 1;
        sample(); chk("lu_stall", bus.stall_front, 1); chk("lu_flush_idex", bus.flush_idex, 1);
        chk("lu_flush_ifid", bus.flush_ifid, 0);
        tick(); clear();
        sample(); chk("lu_after_stall", bus.stall_front, 0); chk("lu_after_flush", bus.flush_idex, 0);
        tick();

        bus.ex_is_load = 1; bus.rd_ex = 7; bus.rs1_id = 3; bus.use_rs1_id = 1;
        bus.rs2_id = 7; bus.use_rs2_id = 1;
        sample(); chk("lu_rs2_stall", bus.stall_front, 1);
        tick(); bus.use_rs2_id = 0;
        sample(); chk("lu_rs2_unused", bus.stall_front, 0);
        tick(); clear();
        bus.ex_is_load = 1; bus.rd_ex = 0; bus.rs1_id = 0; bus.use_rs1_id = 1;
        sample(); chk("lu_x0", bus.stall_front, 0);
        tick(); bus.ex_is_load = 0; bus.rd_ex = 5; bus.rs1_id = 5;
        sample(); chk("no_load", bus.stall_front, 0);
        tick();

        // taken branch, imem idle, with a coincident load-use that must be ignored
        branch(32'h40, 0);
        bus.ex_is_load = 1; bus.rd_ex = 5; bus.rs1_id = 5; bus.use_rs1_id = 1;
        sample(); chk("br_redirect", bus.pc_redirect, 1); chk("br_target", bus.pc_redirect_target, 32'h40);
        chk("br_flush_ifid", bus.flush_ifid, 1); chk("br_flush_idex", bus.flush_idex, 1);
        chk("br_lu_ignored", bus.stall_front, 0);
        tick(); clear();
        sample(); chk("idle_target", bus.pc_redirect_target, 0);
        tick();
        branch(32'h44, 1); bus.imem_resp = 1;
        sample(); chk("br_hit_target", bus.pc_redirect_target, 32'h44);
        tick(); clear(); bus.imem_req = 1;
        sample(); chk("imiss_stall", bus.stall_front, 1); chk("imiss_ifid", bus.flush_ifid, 0);
        tick();

        // redirect deferred behind a 3-cycle imem miss
        branch(32'h80, 1);
        sample(); chk("rw_enter_redirect", bus.pc_redirect, 0); chk("rw_enter_stall", bus.stall_front, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            clear(); bus.imem_req = 1;
            if (i == 1) begin bus.br_taken_ex = 1; bus.br_target_ex = 32'hdead; end
            sample(); chk("rw_wait_stall", bus.stall_front, 1); chk("rw_wait_redirect", bus.pc_redirect, 0);
            tick();
        end
        bus.br_taken_ex = 0; bus.imem_resp = 1;
        sample(); chk("rw_redirect", bus.pc_redirect, 1); chk("rw_target", bus.pc_redirect_target, 32'h80);
        tick(); clear();
        sample(); chk("rw_done", bus.stall_front, 0);
        tick();

        // wait-state completion while frozen
        branch(32'hc0, 1);
        tick(); clear(); bus.dmem_req = 1; bus.imem_req = 1; bus.imem_resp = 1;
        sample(); chk("rwf_redirect", bus.pc_redirect, 1); chk("rwf_target", bus.pc_redirect_target, 32'hc0);
        chk("rwf_freeze", bus.freeze, 1); chk("rwf_flush", bus.flush_ifid, 0);
        tick(); clear();

        // freeze for 4 cycles hides a pending branch
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            branch(32'h100, 0); bus.dmem_req = 1;
            sample(); chk("frz_freeze", bus.freeze, 1); chk("frz_redirect", bus.pc_redirect, 0);
            tick();
        end
        branch(32'h100, 0);
        sample(); chk("frz_after_redirect", bus.pc_redirect, 1);
        chk("frz_after_target", bus.pc_redirect_target, 32'h100);
        chk("frz_perf", bus.perf_stall_cycles, PERF_ON ? 4 : 0);
        tick();

        // reset while waiting discards the pending target
        branch(32'h200, 1);
        tick(); clear(); bus.imem_req = 1;
        sample(); chk("rr_wait", bus.stall_front, 1);
        tick(); rst_n = 0;
        sample(); chk("rr_rst_redirect", bus.pc_redirect, 0); chk("rr_rst_stall", bus.stall_front, 0);
        chk("rr_rst_flush_ifid", bus.flush_ifid, 1);
        tick(); rst_n = 1; bus.imem_resp = 1;
        sample(); chk("rr_no_redirect", bus.pc_redirect, 0); chk("rr_no_target", bus.pc_redirect_target, 0);
        tick();

        // counter wrap
        reset_pulse();
        bus.dmem_req = 1;
        repeat (255) tick();
        sample(); chk("wrap_255", bus.perf_stall_cycles, PERF_ON ? 255 : 0);
        tick();
        sample(); chk("wrap_0", bus.perf_stall_cycles, 0);
        tick(); clear();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
